// File: rtl/polyph_filter_mc_pkg.sv
// Shared types and width helpers for the multi-channel polyphase filter.
package polyph_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Accumulator width: coefficient width, growth over NBAUD taps, plus one
    // bit so that negating the most negative coefficient cannot wrap.
    function automatic int nbt_add(input int nbt_coef, input int nbaud);
        return nbt_coef + $clog2(nbaud) + 32'sd1;
    endfunction

    // Number of fractional LSBs discarded when going to the output format.
    function automatic int nb_drop(input int nbf_in, input int nbf_out);
        return nbf_in - nbf_out;
    endfunction

    // Largest positive value representable in an nbt-bit signed word.
    function automatic int sat_max(input int nbt);
        return (32'sd1 <<< (nbt - 32'sd1)) - 32'sd1;
    endfunction

    // Most negative value representable in an nbt-bit signed word.
    function automatic int sat_min(input int nbt);
        return -(32'sd1 <<< (nbt - 32'sd1));
    endfunction

endpackage

// File: rtl/polyph_sat_trunc.sv
// Combinational truncate-and-saturate from the accumulator to the output format.
module polyph_sat_trunc
    import polyph_pkg::*;
#(
    parameter int NBT_IN  = 11,
    parameter int NBF_IN  = 7,
    parameter int NBT_OUT = 8,
    parameter int NBF_OUT = 7
) (
    input  logic signed [NBT_IN-1:0]  acc,
    output logic signed [NBT_OUT-1:0] sample
);

    localparam int NB_DROP = nb_drop(NBF_IN, NBF_OUT);
    localparam logic signed [NBT_IN-1:0] MAX_V = NBT_IN'(sat_max(NBT_OUT));
    localparam logic signed [NBT_IN-1:0] MIN_V = NBT_IN'(sat_min(NBT_OUT));

    logic signed [NBT_IN-1:0] trunc_s;

    // Drop fractional LSBs (floor), then clamp into the signed output range.
    always_comb begin
        trunc_s = acc >>> NB_DROP;
        if (trunc_s > MAX_V) begin
            sample = MAX_V[NBT_OUT-1:0];
        end else if (trunc_s < MIN_V) begin
            sample = MIN_V[NBT_OUT-1:0];
        end else begin
            sample = trunc_s[NBT_OUT-1:0];
        end
    end

endmodule

// File: rtl/polyph_filter_mc.sv
// Multi-channel polyphase transmit pulse-shaping filter: one antipodal symbol
// per channel per baud in, OS output phases per symbol out, one sample/clock.
module polyph_filter_mc
    import polyph_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int NBAUD    = 6,
    parameter int OS       = 4,
    parameter int NBT_COEF = 8,
    parameter int NBF_COEF = 7,
    parameter int NBT_OUT  = 8,
    parameter int NBF_OUT  = 7,
    parameter     COEF_FILE = ""
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic [NCH-1:0]                    i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic                              i_coef_we,
    input  logic [$clog2(NBAUD*OS)-1:0]       i_coef_addr,
    input  logic signed [NBT_COEF-1:0]        i_coef_data,
    output logic [NCH*NBT_OUT-1:0]            o_data,
    output logic                              o_valid,
    output logic [$clog2(OS)-1:0]             o_phase
);

    localparam int NCOEF     = NBAUD * OS;
    localparam int AW        = $clog2(NCOEF);
    localparam int PW        = $clog2(OS);
    localparam int NBT_ADD_W = nbt_add(NBT_COEF, NBAUD);
    localparam logic [PW-1:0] LAST_PH  = PW'(OS - 1);
    localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(NCOEF);

    state_t                         state_r, state_nx_s;
    logic [PW-1:0]                  phase_r, phase_nx_s;
    logic                           ready_r;
    logic                           accept_s;
    logic [NBAUD-1:0]               sr_r    [NCH];
    logic signed [NBT_COEF-1:0]     coef_r  [NCOEF];
    logic signed [NBT_ADD_W-1:0]    sum_s   [NCH];
    logic signed [NBT_ADD_W-1:0]    term_s;
    logic signed [NBT_OUT-1:0]      sat_s   [NCH];
    logic                           coef_addr_ok_s;

    assign accept_s       = i_valid && ready_r;
    assign o_ready        = ready_r;
    assign coef_addr_ok_s = ({1'b0, i_coef_addr} < ADDR_LIM);

    // Next-state and next-phase logic of the IDLE/RUN sequencer.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = phase_r;
        case (state_r)
            IDLE: begin
                phase_nx_s = '0;
                if (accept_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (phase_r != LAST_PH) begin
                    phase_nx_s = phase_r + 1'b1;
                    state_nx_s = RUN;
                end else if (accept_s) begin
                    phase_nx_s = '0;
                    state_nx_s = RUN;
                end else begin
                    phase_nx_s = '0;
                    state_nx_s = IDLE;
                end
            end
            default: begin
                phase_nx_s = '0;
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sequencer registers; ready is registered from the next state so it is glitch-free.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= IDLE;
            phase_r <= '0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            phase_r <= phase_nx_s;
            ready_r <= (state_nx_s == IDLE) || (phase_nx_s == LAST_PH);
        end
    end

    // Per-channel symbol history: new bit enters tap 0, oldest bit falls off.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                sr_r[c] <= '0;
            end
        end else if (accept_s) begin
            for (int c = 0; c < NCH; c++) begin
                sr_r[c] <= {sr_r[c][NBAUD-2:0], i_data[c]};
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                sr_r[c] <= sr_r[c];
            end
        end
    end

    // Runtime coefficient writes; out-of-range addresses are dropped, contents survive reset.
    always_ff @(posedge clk) begin
        if (i_coef_we && coef_addr_ok_s) begin
            coef_r[i_coef_addr] <= i_coef_data;
        end
    end

    // Polyphase branch sum: add or subtract each tap's coefficient for the current phase.
    always_comb begin
        term_s = '0;
        for (int c = 0; c < NCH; c++) begin
            sum_s[c] = '0;
            for (int k = 0; k < NBAUD; k++) begin
                term_s = NBT_ADD_W'(coef_r[AW'(k * OS) + AW'(phase_r)]);
                if (sr_r[c][k]) begin
                    sum_s[c] = sum_s[c] - term_s;
                end else begin
                    sum_s[c] = sum_s[c] + term_s;
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_sat
        polyph_sat_trunc #(
            .NBT_IN  (NBT_ADD_W),
            .NBF_IN  (NBF_COEF),
            .NBT_OUT (NBT_OUT),
            .NBF_OUT (NBF_OUT)
        ) u_sat (
            .acc    (sum_s[c]),
            .sample (sat_s[c])
        );
    end

    // Output register: capture a sample for every RUN cycle, hold data while idle.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_phase <= '0;
        end else if (state_r == RUN) begin
            for (int c = 0; c < NCH; c++) begin
                o_data[c*NBT_OUT +: NBT_OUT] <= sat_s[c];
            end
            o_valid <= 1'b1;
            o_phase <= phase_r;
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule
